// File: rtl/neosd_clk_gen.sv
// SD card clock generator: prescaler, gated SD clock, bit strobe and power-up init clock burst.
// Latency: clkstrb_o is combinational from the prescaler state; sd_clk_o/sd_clk_en_o are registered (1 cycle).
// Backpressure: stall_i at a strobe suppresses the next SD clock pulse while strobes keep running.
//
// Ports:
//   clk_i, rstn_i     system clock, asynchronous active-low reset
//   enable_i          block enable; low forces the whole generator idle on the next edge
//   div_i             half-period divider; one SD bit period is 2*(div_i+1) clk_i cycles
//   req_cmd_i         SD clock request from the command FSM
//   req_dat_i         SD clock request from the data FSM
//   stall_i           suppress the next period's pulse (data buffer full/empty)
//   init_start_i      single-cycle pulse starting the INIT_CYCLES power-up clock burst
//   clkstrb_o         one-cycle strobe marking the end of each SD bit period
//   sd_clk_en_o       1 = the period now running emits (or at a strobe: emitted) one SD clock pulse
//   sd_clk_o          registered SD card clock pin
//   init_busy_o       power-up init burst in progress
module neosd_clk_gen #(
    parameter int unsigned INIT_CYCLES = 80
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       enable_i,
    input  logic [7:0] div_i,
    input  logic       req_cmd_i,
    input  logic       req_dat_i,
    input  logic       stall_i,
    input  logic       init_start_i,
    output logic       clkstrb_o,
    output logic       sd_clk_en_o,
    output logic       sd_clk_o,
    output logic       init_busy_o
);

    localparam logic [6:0] INIT_LOAD = 7'(INIT_CYCLES);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0] cnt_q,       cnt_d;        // half-period prescaler
    logic       phase_q,     phase_d;      // 0 = low half, 1 = high half of the bit period
    logic       en_q,        en_d;         // pulse enable for the current bit period
    logic       sd_clk_q,    sd_clk_d;     // SD clock pin register
    logic       init_busy_q, init_busy_d;  // init burst running
    logic [6:0] init_cnt_q,  init_cnt_d;   // init pulses still to emit

    logic tick;    // end of a half period
    logic strobe;  // end of a full bit period

    // The >= compare (rather than ==) makes the counter wrap at once when
    // div_i is lowered below the current count, so it can never run away.
    assign tick   = enable_i && (cnt_q >= div_i);
    assign strobe = tick && phase_q;

    // ------------------------------------------------------------------
    // Prescaler and phase
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!enable_i) begin
            cnt_d   = 8'd0;
            phase_d = 1'b0;
        end else if (tick) begin
            cnt_d   = 8'd0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Init burst bookkeeping
    // ------------------------------------------------------------------
    // A start while busy falls through to the decrement branch, i.e. it is
    // ignored and the running burst is not reloaded.
    always_comb begin
        init_busy_d = init_busy_q;
        init_cnt_d  = init_cnt_q;
        if (!enable_i) begin
            init_busy_d = 1'b0;
            init_cnt_d  = 7'd0;
        end else if (init_start_i && !init_busy_q) begin
            init_busy_d = 1'b1;
            init_cnt_d  = INIT_LOAD;
        end else if (strobe && en_q && init_busy_q) begin
            // this strobe closes a period that carried one init pulse
            init_cnt_d = init_cnt_q - 7'd1;
            if (init_cnt_q == 7'd1) begin
                init_busy_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pulse enable: decided only at a strobe, held for the whole period
    // ------------------------------------------------------------------
    // The post-update busy flag is used so the strobe that ends the last
    // init pulse does not grant one extra period to the finished burst.
    always_comb begin
        en_d = en_q;
        if (!enable_i) begin
            en_d = 1'b0;
        end else if (strobe) begin
            en_d = (req_cmd_i || req_dat_i || init_busy_d) && !stall_i;
        end
    end

    // ------------------------------------------------------------------
    // SD clock: low half first, rises mid-period if enabled, falls at strobe
    // ------------------------------------------------------------------
    always_comb begin
        sd_clk_d = sd_clk_q;
        if (!enable_i) begin
            sd_clk_d = 1'b0;
        end else if (tick) begin
            sd_clk_d = phase_q ? 1'b0 : en_q;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q       <= 8'd0;
            phase_q     <= 1'b0;
            en_q        <= 1'b0;
            sd_clk_q    <= 1'b0;
            init_busy_q <= 1'b0;
            init_cnt_q  <= 7'd0;
        end else begin
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            en_q        <= en_d;
            sd_clk_q    <= sd_clk_d;
            init_busy_q <= init_busy_d;
            init_cnt_q  <= init_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign clkstrb_o   = strobe;
    assign sd_clk_en_o = en_q;
    assign sd_clk_o    = sd_clk_q;
    assign init_busy_o = init_busy_q;

endmodule

// File: tb/tb_neosd_clk_gen.sv
// Directed testbench for neosd_clk_gen.
// Inputs are driven and outputs sampled on the falling edge of clk_i.
// Each scenario task carries its own expected values.
module tb_neosd_clk_gen;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic       enable_i;
    logic [7:0] div_i;
    logic       req_cmd_i;
    logic       req_dat_i;
    logic       stall_i;
    logic       init_start_i;
    logic       clkstrb_o;
    logic       sd_clk_en_o;
    logic       sd_clk_o;
    logic       init_busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    neosd_clk_gen #(.INIT_CYCLES(80)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .enable_i     (enable_i),
        .div_i        (div_i),
        .req_cmd_i    (req_cmd_i),
        .req_dat_i    (req_dat_i),
        .stall_i      (stall_i),
        .init_start_i (init_start_i),
        .clkstrb_o    (clkstrb_o),
        .sd_clk_en_o  (sd_clk_en_o),
        .sd_clk_o     (sd_clk_o),
        .init_busy_o  (init_busy_o)
    );

    // Reset, configure, and release on a falling edge (cycle r: cnt=0, phase=0).
    task automatic apply_reset(input logic [7:0] div, input logic en);
        rstn_i       = 1'b0;
        enable_i     = en;
        div_i        = div;
        req_cmd_i    = 1'b0;
        req_dat_i    = 1'b0;
        stall_i      = 1'b0;
        init_start_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    task automatic wait_strobe(input int budget, input string name, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < budget) begin
            @(negedge clk_i);
            cyc++;
            if (clkstrb_o === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: no strobe within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset;
        rstn_i = 1'b0; enable_i = 1'b1; div_i = 8'd0;
        req_cmd_i = 1'b1; req_dat_i = 1'b1; stall_i = 1'b0; init_start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        n_checks++;
        if ({clkstrb_o, sd_clk_en_o, sd_clk_o, init_busy_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0000",
                     {clkstrb_o, sd_clk_en_o, sd_clk_o, init_busy_o});
        end
    endtask

    // div=0, no requests: strobe every 2 cycles, SD clock silent.
    task automatic test_idle_div0;
        logic [2:0] exp;
        apply_reset(8'd0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            if (i != 0) @(negedge clk_i);
            exp = {1'(i % 2), 2'b00};
            n_checks++;
            if ({clkstrb_o, sd_clk_en_o, sd_clk_o} !== exp) begin
                n_fail++;
                $display("FAIL idle_div0 cycle %0d: {strb,en,clk}=%b expected %b",
                         i, {clkstrb_o, sd_clk_en_o, sd_clk_o}, exp);
            end
        end
    endtask

    // div=3, req_cmd: first strobe 8 cycles after release, then 4 low / 4 high.
    task automatic test_cmd_div3;
        int cyc;
        logic [15:0] e_strb, e_clk, e_en;
        e_strb = 16'b1000_0000_1000_0000;
        e_clk  = 16'b0000_0000_1111_0000;
        e_en   = 16'b0000_0000_1111_1111;
        apply_reset(8'd3, 1'b1);
        req_cmd_i = 1'b1;
        wait_strobe(40, "cmd_div3_first", cyc);
        n_checks++;
        if (cyc !== 7) begin
            n_fail++;
            $display("FAIL cmd_div3_first_latency: strobe cycle %0d expected 7", cyc);
        end
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk_i);
            n_checks++;
            if ({clkstrb_o, sd_clk_en_o, sd_clk_o} !== {e_strb[i-1], e_en[i-1], e_clk[i-1]}) begin
                n_fail++;
                $display("FAIL cmd_div3 cycle S+%0d: {strb,en,clk}=%b expected %b", i,
                         {clkstrb_o, sd_clk_en_o, sd_clk_o}, {e_strb[i-1], e_en[i-1], e_clk[i-1]});
            end
            if (i == 8) req_cmd_i = 1'b0;
        end
    endtask

    // div=1, req_dat, stall asserted at one strobe: one silent period, strobes every 4.
    task automatic test_stall_div1;
        int cyc;
        logic [11:0] e_strb, e_clk, e_en;
        e_strb = 12'b1000_1000_1000;
        e_clk  = 12'b1100_0000_1100;
        e_en   = 12'b1111_0000_1111;
        apply_reset(8'd1, 1'b1);
        req_dat_i = 1'b1;
        wait_strobe(20, "stall_first", cyc);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk_i);
            n_checks++;
            if ({clkstrb_o, sd_clk_en_o, sd_clk_o} !== {e_strb[i-1], e_en[i-1], e_clk[i-1]}) begin
                n_fail++;
                $display("FAIL stall_div1 cycle S+%0d: {strb,en,clk}=%b expected %b", i,
                         {clkstrb_o, sd_clk_en_o, sd_clk_o}, {e_strb[i-1], e_en[i-1], e_clk[i-1]});
            end
            if (i == 3) stall_i = 1'b1;
            if (i == 5) stall_i = 1'b0;
        end
        req_dat_i = 1'b0;
    endtask

    // div=0 init burst: exactly 80 pulses, busy falls at the strobe closing pulse 80,
    // a second start mid-burst is ignored.
    task automatic test_init;
        int rises, extra, cyc;
        logic prev_clk, last_strb, last_clk, last_en, done, second_sent;
        rises = 0; extra = 0; cyc = 0;
        prev_clk = 1'b0; last_strb = 1'b0; last_clk = 1'b0; last_en = 1'b0;
        done = 1'b0; second_sent = 1'b0;
        apply_reset(8'd0, 1'b1);
        @(negedge clk_i);
        init_start_i = 1'b1;
        @(negedge clk_i);
        init_start_i = 1'b0;
        n_checks++;
        if (init_busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL init_busy_set: got %b expected 1", init_busy_o);
        end
        while (!done && cyc < 400) begin
            @(negedge clk_i);
            cyc++;
            if (init_busy_o === 1'b0) begin
                done = 1'b1;
            end else begin
                if (sd_clk_o === 1'b1 && prev_clk === 1'b0) rises++;
                prev_clk  = sd_clk_o;
                last_strb = clkstrb_o;
                last_clk  = sd_clk_o;
                last_en   = sd_clk_en_o;
                if (rises == 20 && !second_sent) begin
                    init_start_i = 1'b1;
                    second_sent  = 1'b1;
                end else begin
                    init_start_i = 1'b0;
                end
            end
        end
        init_start_i = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL init_done: busy still %b after %0d cycles expected 0", init_busy_o, cyc);
        end
        n_checks++;
        if (rises != 80) begin
            n_fail++;
            $display("FAIL init_pulse_count: got %0d expected 80", rises);
        end
        n_checks++;
        if ({last_strb, last_en, last_clk} !== 3'b111) begin
            n_fail++;
            $display("FAIL init_busy_fall_point: last busy cycle {strb,en,clk}=%b expected 111",
                     {last_strb, last_en, last_clk});
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (sd_clk_o === 1'b1 && prev_clk === 1'b0) extra++;
            prev_clk = sd_clk_o;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL init_no_extra_pulse: got %0d extra rises expected 0", extra);
        end
    endtask

    // Reset asserted during the 40th init pulse clears everything asynchronously.
    task automatic test_reset_mid_init;
        int rises, cyc;
        logic prev_clk;
        rises = 0; cyc = 0; prev_clk = 1'b0;
        apply_reset(8'd0, 1'b1);
        @(negedge clk_i);
        init_start_i = 1'b1;
        @(negedge clk_i);
        init_start_i = 1'b0;
        while (rises < 40 && cyc < 300) begin
            @(negedge clk_i);
            cyc++;
            if (sd_clk_o === 1'b1 && prev_clk === 1'b0) rises++;
            prev_clk = sd_clk_o;
        end
        n_checks++;
        if ({sd_clk_o, init_busy_o} !== 2'b11) begin
            n_fail++;
            $display("FAIL midinit_precondition: {clk,busy}=%b after %0d rises expected 11",
                     {sd_clk_o, init_busy_o}, rises);
        end
        rstn_i = 1'b0;
        #1;
        n_checks++;
        if ({clkstrb_o, sd_clk_en_o, sd_clk_o, init_busy_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL midinit_async_reset: {strb,en,clk,busy}=%b expected 0000",
                     {clkstrb_o, sd_clk_en_o, sd_clk_o, init_busy_o});
        end
        @(negedge clk_i);
    endtask

    // enable_i dropped mid-pulse: clock low next edge, no strobes; re-enable restarts cleanly.
    task automatic test_disable_mid_pulse;
        int cyc, strobes;
        strobes = 0;
        apply_reset(8'd3, 1'b1);
        req_cmd_i = 1'b1;
        wait_strobe(40, "disable_first", cyc);
        repeat (5) @(negedge clk_i);
        n_checks++;
        if (sd_clk_o !== 1'b1) begin
            n_fail++;
            $display("FAIL disable_precondition: sd_clk %b expected 1", sd_clk_o);
        end
        enable_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({clkstrb_o, sd_clk_en_o, sd_clk_o, init_busy_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL disable_force_idle: {strb,en,clk,busy}=%b expected 0000",
                     {clkstrb_o, sd_clk_en_o, sd_clk_o, init_busy_o});
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (clkstrb_o !== 1'b0 || sd_clk_o !== 1'b0) strobes++;
        end
        n_checks++;
        if (strobes != 0) begin
            n_fail++;
            $display("FAIL disable_no_activity: %0d active cycles expected 0", strobes);
        end
        enable_i = 1'b1;
        wait_strobe(40, "reenable_first", cyc);
        n_checks++;
        if (cyc !== 7) begin
            n_fail++;
            $display("FAIL reenable_latency: strobe cycle %0d expected 7", cyc);
        end
        req_cmd_i = 1'b0;
    endtask

    // div 7 -> 2 with cnt=5: immediate wrap, then 3-cycle half periods.
    task automatic test_div_shrink;
        logic [8:0] e_strb, e_clk, e_en;
        e_strb = 9'b1_0000_0100;
        e_clk  = 9'b1_1100_0000;
        e_en   = 9'b1_1111_1000;
        apply_reset(8'd7, 1'b1);
        req_cmd_i = 1'b1;
        repeat (5) @(negedge clk_i);
        div_i = 8'd2;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_i);
            n_checks++;
            if ({clkstrb_o, sd_clk_en_o, sd_clk_o} !== {e_strb[i], e_en[i], e_clk[i]}) begin
                n_fail++;
                $display("FAIL div_shrink cycle r+%0d: {strb,en,clk}=%b expected %b", i + 6,
                         {clkstrb_o, sd_clk_en_o, sd_clk_o}, {e_strb[i], e_en[i], e_clk[i]});
            end
        end
        req_cmd_i = 1'b0;
    endtask

    initial begin
        test_reset;
        test_idle_div0;
        test_cmd_div3;
        test_stall_div1;
        test_init;
        test_reset_mid_init;
        test_disable_mid_pulse;
        test_div_shrink;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/neosd_clk_gen.md
NEOSD_CLK_GEN -- requirements
Module: neosd_clk_gen

Interface
REQ-001 Parameter INIT_CYCLES, default 80: number of SD clock pulses emitted by the card power-up init sequence, valid range 1..127.
REQ-002 clk_i  in  1  system clock; every register updates on its rising edge.
REQ-003 rstn_i  in  1  asynchronous, active-low reset.
REQ-004 enable_i  in  1  block enable; 0 stops the prescaler and the SD clock.
REQ-005 div_i  in  8  half-period divider; SD bit period is 2*(div_i+1) clk_i cycles.
REQ-006 req_cmd_i  in  1  SD clock request from the command FSM.
REQ-007 req_dat_i  in  1  SD clock request from the data FSM.
REQ-008 stall_i  in  1  clock stall request (data buffer full or empty).
REQ-009 init_start_i  in  1  single-cycle pulse that starts the init clock sequence.
REQ-010 clkstrb_o  out  1  one-cycle bit strobe that marks the end of each SD bit period.
REQ-011 sd_clk_en_o  out  1  1 = the SD clock pulse of the current bit period is emitted.
REQ-012 sd_clk_o  out  1  SD card clock pin, registered.
REQ-013 init_busy_o  out  1  init sequence in progress.

Function
REQ-014 The block SHALL hold an 8-bit counter cnt, a phase bit, an en register driving sd_clk_en_o, an sd_clk_o register, init_busy and a 7-bit init counter.
REQ-015 tick = enable_i && (cnt >= div_i); on tick cnt SHALL go to 0 and phase SHALL toggle, else cnt SHALL increment; the >= compare guarantees wrap when div_i shrinks below cnt.
REQ-016 clkstrb_o SHALL be combinational: tick && phase==1; strobes are spaced exactly 2*(div_i+1) cycles apart (div_i=0 gives a strobe every 2 cycles).
REQ-017 On the strobe cycle, en SHALL load enable_i && (req_cmd_i || req_dat_i || init_busy) && !stall_i; en holds for the whole following bit period.
REQ-018 On a tick with phase==0, sd_clk_o SHALL load en; on a tick with phase==1, sd_clk_o SHALL load 0; duty cycle is 50 %, the low half comes first after each strobe, and the rising edge falls mid-period.
REQ-019 At a strobe, sd_clk_en_o==1 SHALL mean exactly one sd_clk_o high pulse occurred in the period now ending; consumers shift or sample only on clkstrb_o && sd_clk_en_o.
REQ-020 When stall_i is 1 at a strobe, the next period SHALL have no high pulse, and strobes SHALL continue.
REQ-021 init_start_i while !init_busy and enable_i SHALL set init_busy=1 and init counter=INIT_CYCLES; init_start_i while busy SHALL be ignored.
REQ-022 At each strobe with en==1 and init_busy==1, the init counter SHALL decrement; the strobe that takes it from 1 to 0 SHALL clear init_busy in the same update.
REQ-023 enable_i==0 SHALL force, on the next edge: cnt=0, phase=0, en=0, sd_clk_o=0, init_busy=0; no strobes SHALL occur while enable_i is 0.
REQ-024 Requests that change between strobes SHALL take effect only at the next strobe; the clock is never truncated mid-pulse.
REQ-025 A div_i change while en==1 is illegal usage; the block SHALL still wrap per REQ-015 and never lock up.

Reset
REQ-026 Assertion of rstn_i SHALL immediately clear cnt, phase, en, sd_clk_o, init_busy and the init counter, giving clkstrb_o=0, sd_clk_en_o=0, sd_clk_o=0 and init_busy_o=0, including mid-pulse and mid-init.
REQ-027 After reset release with enable_i=1, the first strobe SHALL occur 2*(div_i+1) cycles later.

Verification
REQ-028 enable=1, div=0, no requests -> clkstrb_o every 2 cycles; sd_clk_o and sd_clk_en_o constantly 0.
REQ-029 div=3, req_cmd_i=1 before strobe S -> from S+1, sd_clk_o is low 4 cycles then high 4 cycles; sd_clk_en_o=1 at the next strobe; period is 8 cycles.
REQ-030 div=1, req_dat_i=1, stall_i=1 only at one strobe -> exactly one period with no sd_clk_o pulse; strobe spacing stays 4 cycles.
REQ-031 INIT_CYCLES=80, div=0, init_start_i pulse -> exactly 80 sd_clk_o rising edges; init_busy_o falls at the strobe ending the 80th pulse; a second init_start_i mid-sequence is ignored.
REQ-032 div=7 with cnt=5, div_i changed to 2 -> tick on the next cycle, then 3-cycle half periods.
REQ-033 rstn_i low during the 40th init pulse (sd_clk_o=1) -> all outputs 0 asynchronously; enable_i=0 mid-pulse -> sd_clk_o=0 and no further strobes.
